// File: rtl/uart_mmio.sv
// Memory-mapped UART: DATA/STATUS registers, a TX FIFO feeding a serialiser, and an
// RX deserialiser with a single-entry holding register.
module uart_mmio #(
  parameter logic [15:0] BASE_ADDR  = 16'h7F80,
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        write_enable,
  input  logic        byte_enable,
  input  logic        byte_select,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        serviced_read,
  input  logic        uart_rx,
  output logic        uart_tx
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [15:0]   STAT_ADDR = BASE_ADDR + 16'd1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic          en_d_q, en_d_d;
  logic [15:0]   data_out_q, data_out_d;
  logic          serviced_read_q, serviced_read_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  uart_state_e   tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic          uart_tx_q, uart_tx_d;
  logic [1:0]    rx_sync_q, rx_sync_d;
  logic          rx_prev_q, rx_prev_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_overrun_q, rx_overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          tx_drop_q, tx_drop_d;

  logic          access, hit_data, hit_stat, data_rd, push, tx_pop;
  logic          fifo_empty, fifo_full, tx_busy, rx_in;
  logic [7:0]    wr_byte;

  // Bus decode, FIFO, TX and RX next-state logic.
  always_comb begin
    en_d_d          = en;
    data_out_d      = data_out_q;
    serviced_read_d = serviced_read_q;
    mem_d           = mem_q;
    head_d          = head_q;
    tail_d          = tail_q;
    tx_state_d      = tx_state_q;
    tx_cnt_d        = tx_cnt_q;
    tx_bit_d        = tx_bit_q;
    tx_shift_d      = tx_shift_q;
    uart_tx_d       = 1'b1;
    rx_sync_d       = {rx_sync_q[0], uart_rx};
    rx_prev_d       = rx_sync_q[1];
    rx_state_d      = rx_state_q;
    rx_cnt_d        = rx_cnt_q;
    rx_bit_d        = rx_bit_q;
    rx_shift_d      = rx_shift_q;
    rx_byte_d       = rx_byte_q;
    rx_valid_d      = rx_valid_q;
    rx_overrun_d    = rx_overrun_q;
    frame_err_d     = frame_err_q;
    tx_drop_d       = tx_drop_q;

    access     = en && !en_d_q;
    hit_data   = (addr == BASE_ADDR);
    hit_stat   = (addr == STAT_ADDR);
    data_rd    = access && !write_enable && hit_data;
    push       = access && write_enable && hit_data;
    wr_byte    = (byte_enable && byte_select) ? data_in[15:8] : data_in[7:0];
    fifo_empty = (head_q == tail_q);
    fifo_full  = (head_q[PW-1] != tail_q[PW-1]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
    tx_busy    = (tx_state_q != S_IDLE);
    rx_in      = rx_sync_q[1];
    // Popping at the end of a stop bit keeps frames back-to-back.
    tx_pop     = !fifo_empty &&
                 ((tx_state_q == S_IDLE) || ((tx_state_q == S_STOP) && (tx_cnt_q == '0)));

    // Reads capture the old flags; clears happen here so later sets win.
    if (access) begin
      if (!write_enable && (hit_data || hit_stat)) begin
        serviced_read_d = 1'b1;
        if (hit_data) begin
          data_out_d = {8'h00, rx_byte_q};
          rx_valid_d = 1'b0;
        end else begin
          data_out_d   = {9'b0, tx_drop_q, frame_err_q, rx_overrun_q, rx_valid_q,
                          tx_busy, fifo_empty, fifo_full};
          tx_drop_d    = 1'b0;
          frame_err_d  = 1'b0;
          rx_overrun_d = 1'b0;
        end
      end else begin
        serviced_read_d = 1'b0;
      end
    end

    if (push) begin
      if (!fifo_full || tx_pop) begin
        mem_d[tail_q[AW-1:0]] = wr_byte;
        tail_d                = tail_q + PW'(1);
      end else begin
        tx_drop_d = 1'b1;
      end
    end

    case (tx_state_q)
      S_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = BIT_LAST;
          tx_bit_d   = 3'd0;
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = BIT_LAST;
          tx_shift_d = {1'b1, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (tx_cnt_q == '0) tx_state_d = S_IDLE;
        else                tx_cnt_d   = tx_cnt_q - CW'(1);
      end
      default: ;
    endcase

    if (tx_pop) begin
      tx_state_d = S_START;
      tx_cnt_d   = BIT_LAST;
      tx_shift_d = mem_q[head_q[AW-1:0]];
      head_d     = head_q + PW'(1);
    end

    case (tx_state_d)
      S_START: uart_tx_d = 1'b0;
      S_DATA:  uart_tx_d = tx_shift_d[0];
      default: uart_tx_d = 1'b1;
    endcase

    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_in) begin
          rx_state_d = S_START;
          rx_cnt_d   = HALF_LAST;
        end
      end
      S_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_in) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_state_d = S_DATA;
            rx_cnt_d   = BIT_LAST;
            rx_bit_d   = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = BIT_LAST;
          rx_shift_d = {rx_in, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = S_IDLE;
          if (rx_in) begin
            rx_byte_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !data_rd) rx_overrun_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_d_q          <= 1'b0;
      data_out_q      <= '0;
      serviced_read_q <= 1'b0;
      head_q          <= '0;
      tail_q          <= '0;
      tx_state_q      <= S_IDLE;
      tx_cnt_q        <= '0;
      tx_bit_q        <= '0;
      tx_shift_q      <= '0;
      uart_tx_q       <= 1'b1;
      rx_sync_q       <= 2'b11;
      rx_prev_q       <= 1'b1;
      rx_state_q      <= S_IDLE;
      rx_cnt_q        <= '0;
      rx_bit_q        <= '0;
      rx_shift_q      <= '0;
      rx_byte_q       <= '0;
      rx_valid_q      <= 1'b0;
      rx_overrun_q    <= 1'b0;
      frame_err_q     <= 1'b0;
      tx_drop_q       <= 1'b0;
    end else begin
      en_d_q          <= en_d_d;
      data_out_q      <= data_out_d;
      serviced_read_q <= serviced_read_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      tx_state_q      <= tx_state_d;
      tx_cnt_q        <= tx_cnt_d;
      tx_bit_q        <= tx_bit_d;
      tx_shift_q      <= tx_shift_d;
      uart_tx_q       <= uart_tx_d;
      rx_sync_q       <= rx_sync_d;
      rx_prev_q       <= rx_prev_d;
      rx_state_q      <= rx_state_d;
      rx_cnt_q        <= rx_cnt_d;
      rx_bit_q        <= rx_bit_d;
      rx_shift_q      <= rx_shift_d;
      rx_byte_q       <= rx_byte_d;
      rx_valid_q      <= rx_valid_d;
      rx_overrun_q    <= rx_overrun_d;
      frame_err_q     <= frame_err_d;
      tx_drop_q       <= tx_drop_d;
    end
  end

  // FIFO storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign data_out      = data_out_q;
  assign serviced_read = serviced_read_q;
  assign uart_tx       = uart_tx_q;
endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: TX frames and RX bytes are checked against
// scoreboard queues filled when the stimulus is driven.
module tb_uart_mmio;
  localparam logic [15:0] BASE = 16'h7F80;
  localparam int unsigned DIV  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, write_enable = 1'b0, byte_enable = 1'b0, byte_select = 1'b0;
  logic [15:0] addr = '0, data_in = '0;
  logic [15:0] data_out;
  logic        serviced_read;
  logic        uart_rx = 1'b1;
  logic        uart_tx;

  int          checks = 0;
  int          passed = 0;
  int          tx_frames = 0;
  logic [7:0]  tx_sb [$];
  logic [7:0]  rx_sb [$];
  logic [7:0]  rx_last = 8'h00;

  uart_mmio #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .write_enable(write_enable),
    .byte_enable(byte_enable), .byte_select(byte_select), .addr(addr),
    .data_in(data_in), .data_out(data_out), .serviced_read(serviced_read),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // TX monitor: decodes each frame, checks bit widths, compares with the scoreboard.
  initial begin : tx_mon
    logic [7:0] got, exp;
    logic       ok;
    forever begin
      @(posedge clk); #2;
      if (uart_tx === 1'b0) begin
        ok = 1'b1;
        for (int i = 1; i < DIV; i++) begin
          @(posedge clk); #2;
          if (uart_tx !== 1'b0) ok = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
          for (int i = 0; i < DIV; i++) begin
            @(posedge clk); #2;
            if (i == 0) got[b] = uart_tx;
            else if (uart_tx !== got[b]) ok = 1'b0;
          end
        end
        for (int i = 0; i < DIV; i++) begin
          @(posedge clk); #2;
          if (uart_tx !== 1'b1) ok = 1'b0;
        end
        tx_frames++;
        checks++;
        if (tx_sb.size() == 0) begin
          $display("FAIL tx_unexpected: frame 0x%02h seen, required no frame", got);
        end else begin
          exp = tx_sb.pop_front();
          if (!ok || got !== exp)
            $display("FAIL tx_frame: got 0x%02h shape_ok=%0b, required 0x%02h shape_ok=1",
                     got, ok, exp);
          else passed++;
        end
      end
    end
  end

  task automatic bus_op(input logic we, input logic [15:0] a, input logic [15:0] d,
                        input logic be, input logic bs);
    @(posedge clk); #1;
    en = 1'b1; write_enable = we; addr = a; data_in = d; byte_enable = be; byte_select = bs;
    @(posedge clk); #1;
    en = 1'b0; write_enable = 1'b0; byte_enable = 1'b0; byte_select = 1'b0;
  endtask

  task automatic wait_tx_drain(input string name);
    int n = 0;
    while (tx_sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (tx_sb.size() != 0)
      $display("FAIL %s_drain: %0d frames pending, required 0", name, tx_sb.size());
    else passed++;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    if (stop) rx_sb.push_back(b);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      uart_rx = frame[k];
      repeat (DIV - 1) @(posedge clk);
    end
    @(posedge clk); #1;
    uart_rx = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (uart_tx !== 1'b1) $display("FAIL reset_tx: got %b, required 1", uart_tx); else passed++;
    checks++; if (data_out !== 16'h0000) $display("FAIL reset_data_out: got 0x%04h, required 0x0000", data_out); else passed++;
    checks++; if (serviced_read !== 1'b0) $display("FAIL reset_srv: got %b, required 0", serviced_read); else passed++;
    rst_n = 1'b1;
    bus_op(1'b0, BASE + 16'd1, 16'h0, 1'b0, 1'b0);
    checks++; if (data_out !== 16'h0002 || serviced_read !== 1'b1)
      $display("FAIL reset_status: got 0x%04h srv=%b, required 0x0002 srv=1", data_out, serviced_read);
    else passed++;
  endtask

  task automatic test_tx_single();
    int f0 = tx_frames;
    tx_sb.push_back(8'h55);
    bus_op(1'b1, BASE, 16'h0055, 1'b0, 1'b0);
    checks++; if (uart_tx !== 1'b1) $display("FAIL tx_latency_n1: got %b, required 1", uart_tx); else passed++;
    @(posedge clk); #1;
    checks++; if (uart_tx !== 1'b0) $display("FAIL tx_latency_n2: got %b, required 0", uart_tx); else passed++;
    bus_op(1'b0, BASE + 16'd1, 16'h0, 1'b0, 1'b0);
    checks++; if (data_out !== 16'h0006)
      $display("FAIL tx_status_busy: got 0x%04h, required 0x0006", data_out); else passed++;
    wait_tx_drain("tx_single");
    checks++; if (tx_frames - f0 !== 1)
      $display("FAIL tx_single_count: got %0d frames, required 1", tx_frames - f0); else passed++;
  endtask

  task automatic test_fifo_full();
    int f0 = tx_frames;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) tx_sb.push_back(8'(8'h80 + i));
      bus_op(1'b1, BASE, 16'(16'h0080 + i), 1'b0, 1'b0);
    end
    bus_op(1'b0, BASE + 16'd1, 16'h0, 1'b0, 1'b0);
    checks++; if (data_out !== 16'h0045)
      $display("FAIL fifo_full_status: got 0x%04h, required 0x0045", data_out); else passed++;
    bus_op(1'b0, BASE + 16'd1, 16'h0, 1'b0, 1'b0);
    checks++; if (data_out !== 16'h0005)
      $display("FAIL fifo_drop_clear: got 0x%04h, required 0x0005", data_out); else passed++;
    wait_tx_drain("fifo_full");
    repeat (60) @(posedge clk);
    checks++; if (tx_frames - f0 !== 9)
      $display("FAIL fifo_frame_count: got %0d, required 9", tx_frames - f0); else passed++;
  endtask

  task automatic test_rx_byte();
    logic [7:0] exp;
    rx_send(8'hA3, 1'b1);
    bus_op(1'b0, BASE + 16'd1, 16'h0, 1'b0, 1'b0);
    checks++; if (data_out !== 16'h000A)
      $display("FAIL rx_valid_status: got 0x%04h, required 0x000A", data_out); else passed++;
    exp = rx_sb[$]; rx_last = exp; rx_sb.delete();
    bus_op(1'b0, BASE, 16'h0, 1'b0, 1'b0);
    checks++; if (data_out !== {8'h00, exp} || serviced_read !== 1'b1)
      $display("FAIL rx_data: got 0x%04h srv=%b, required 0x%04h srv=1", data_out, serviced_read, {8'h00, exp});
    else passed++;
    bus_op(1'b0, BASE + 16'd1, 16'h0, 1'b0, 1'b0);
    checks++; if (data_out !== 16'h0002)
      $display("FAIL rx_valid_clear: got 0x%04h, required 0x0002", data_out); else passed++;
  endtask

  task automatic test_rx_errors();
    logic [7:0] exp;
    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    bus_op(1'b0, BASE + 16'd1, 16'h0, 1'b0, 1'b0);
    checks++; if (data_out !== 16'h001A)
      $display("FAIL rx_overrun_status: got 0x%04h, required 0x001A", data_out); else passed++;
    exp = rx_sb[$]; rx_last = exp; rx_sb.delete();
    bus_op(1'b0, BASE, 16'h0, 1'b0, 1'b0);
    checks++; if (data_out !== {8'h00, exp})
      $display("FAIL rx_overrun_data: got 0x%04h, required 0x%04h", data_out, {8'h00, exp}); else passed++;
    rx_send(8'h33, 1'b1);
    rx_send(8'h44, 1'b0);
    bus_op(1'b0, BASE + 16'd1, 16'h0, 1'b0, 1'b0);
    checks++; if (data_out !== 16'h002A)
      $display("FAIL rx_frame_err_status: got 0x%04h, required 0x002A", data_out); else passed++;
    exp = rx_sb[$]; rx_last = exp; rx_sb.delete();
    bus_op(1'b0, BASE, 16'h0, 1'b0, 1'b0);
    checks++; if (data_out !== {8'h00, exp})
      $display("FAIL rx_frame_err_data: got 0x%04h, required 0x%04h", data_out, {8'h00, exp}); else passed++;
    @(posedge clk); #1; uart_rx = 1'b0;
    @(posedge clk); #1; uart_rx = 1'b1;
    repeat (50) @(posedge clk);
    bus_op(1'b0, BASE + 16'd1, 16'h0, 1'b0, 1'b0);
    checks++; if (data_out !== 16'h0002)
      $display("FAIL rx_glitch_status: got 0x%04h, required 0x0002", data_out); else passed++;
    bus_op(1'b0, BASE, 16'h0, 1'b0, 1'b0);
    checks++; if (data_out !== {8'h00, rx_last} || serviced_read !== 1'b1)
      $display("FAIL rx_empty_read: got 0x%04h srv=%b, required 0x%04h srv=1", data_out, serviced_read, {8'h00, rx_last});
    else passed++;
  endtask

  task automatic test_bus_rules();
    int f0 = tx_frames;
    tx_sb.push_back(8'h3C);
    @(posedge clk); #1;
    en = 1'b1; write_enable = 1'b1; addr = BASE; data_in = 16'h003C;
    repeat (3) @(posedge clk);
    #1; en = 1'b0; write_enable = 1'b0;
    wait_tx_drain("hold_en");
    checks++; if (tx_frames - f0 !== 1)
      $display("FAIL hold_en_count: got %0d frames, required 1", tx_frames - f0); else passed++;
    bus_op(1'b0, BASE + 16'd1, 16'h0, 1'b0, 1'b0);
    bus_op(1'b0, BASE + 16'd2, 16'h0, 1'b0, 1'b0);
    checks++; if (serviced_read !== 1'b0 || data_out !== 16'h0002)
      $display("FAIL miss_read: got srv=%b data=0x%04h, required srv=0 data=0x0002", serviced_read, data_out);
    else passed++;
    f0 = tx_frames;
    bus_op(1'b0, BASE + 16'd1, 16'h0, 1'b0, 1'b0);
    bus_op(1'b1, BASE + 16'd1, 16'h00FF, 1'b0, 1'b0);
    checks++; if (serviced_read !== 1'b0)
      $display("FAIL store_clears_srv: got %b, required 0", serviced_read); else passed++;
    tx_sb.push_back(8'h41);
    bus_op(1'b1, BASE, 16'h4100, 1'b1, 1'b1);
    tx_sb.push_back(8'h42);
    bus_op(1'b1, BASE, 16'h4142, 1'b0, 1'b1);
    wait_tx_drain("byte_lane");
    checks++; if (tx_frames - f0 !== 2)
      $display("FAIL byte_lane_count: got %0d frames, required 2", tx_frames - f0); else passed++;
  endtask

  initial begin : main
    test_reset();
    test_tx_single();
    test_fifo_full();
    test_rx_byte();
    test_rx_errors();
    test_bus_rules();
    repeat (10) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
